// File: rtl/burst_memory_responder.sv
// Memory-side responder for the 4-beat x 64-bit cache-line burst protocol.
// Holds MEM_LINES 256-bit lines; reads stream out after LATENCY cycles, writes commit atomically.
module burst_memory_responder #(
  parameter int MEM_LINES = 256,
  parameter int LATENCY   = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [63:0] burst_i,
  output logic [63:0] burst_o,
  output logic        resp_o,
  output logic        protocol_err_o
);

  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] BURST = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [255:0]     mem [0:MEM_LINES-1];

  logic [1:0]       state_r;
  logic             op_write_r;
  logic [IDX_W-1:0] idx_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       beat_r;
  // Holds the line fetched at accept (read) or the staged beats (write).
  logic [255:0]     line_r;

  logic [IDX_W-1:0] idx_s;
  logic             req_held_s;
  logic [1:0]       next_beat_s;
  logic             commit_s;

  assign idx_s       = address_i[5 +: IDX_W];
  assign req_held_s  = op_write_r ? write_i : read_i;
  assign next_beat_s = beat_r + 2'd1;
  // Reset on the final-beat edge must suppress the commit, so it is gated here.
  assign commit_s    = (state_r == BURST) && op_write_r && write_i &&
                       (beat_r == 2'd3) && !reset_n;

  // Transaction sequencing, response strobe and read beat output.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_r        <= IDLE;
      resp_o         <= 1'b0;
      burst_o        <= 64'd0;
      protocol_err_o <= 1'b0;
      op_write_r     <= 1'b0;
      idx_r          <= '0;
      cnt_r          <= '0;
      beat_r         <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          resp_o  <= 1'b0;
          burst_o <= 64'd0;
          if (read_i || write_i) begin
            state_r    <= WAIT;
            cnt_r      <= '0;
            idx_r      <= idx_s;
            op_write_r <= write_i && !read_i;
            line_r     <= mem[idx_s];
            if (read_i && write_i) begin
              protocol_err_o <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (!req_held_s) begin
            state_r <= IDLE;
          end else if (cnt_r == CNT_W'(LATENCY - 1)) begin
            state_r <= BURST;
            beat_r  <= 2'd0;
            resp_o  <= 1'b1;
            burst_o <= op_write_r ? 64'd0 : line_r[63:0];
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        BURST: begin
          if (!req_held_s) begin
            state_r <= IDLE;
            resp_o  <= 1'b0;
            burst_o <= 64'd0;
          end else begin
            if (op_write_r) begin
              line_r[{beat_r, 6'd0} +: 64] <= burst_i;
            end
            if (beat_r == 2'd3) begin
              state_r <= DONE;
              resp_o  <= 1'b0;
              burst_o <= 64'd0;
            end else begin
              beat_r  <= next_beat_s;
              burst_o <= op_write_r ? 64'd0 : line_r[{next_beat_s, 6'd0} +: 64];
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          resp_o  <= 1'b0;
          burst_o <= 64'd0;
        end
        default: begin
          state_r <= IDLE;
          resp_o  <= 1'b0;
          burst_o <= 64'd0;
        end
      endcase
    end
  end

  // Atomic whole-line write once the fourth beat is on burst_i.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      mem[idx_r] <= {burst_i, line_r[191:0]};
    end
  end

endmodule

// File: doc/burst_memory_responder.md
Name: burst_memory_responder

Overview:
- Memory-side responder for the 4-beat, 64-bit burst protocol used between the cacheline adaptor and main memory.
- Accepts read and write requests for 256-bit (32-byte) cache lines.
- Streams read data as 4 consecutive 64-bit beats and collects write data as 4 consecutive beats.
- Stores lines in an internal array and serves as the synthesizable/simulation memory model at the bottom of the hierarchy.

Parameters:
- MEM_LINES, 256, number of 256-bit lines stored; power of 2, at least 2.
- LATENCY, 3, cycles from request acceptance to first resp_o beat; at least 1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset_n  input  1  synchronous reset, asserted HIGH (codebase name kept; active-high despite suffix).
- address_i  input  32  byte address of the line; bits [4:0] ignored; line index = address_i[5 +: log2(MEM_LINES)]; upper bits ignored (wrap).
- read_i  input  1  read request; held high by the requester until the last beat.
- write_i  input  1  write request; held high by the requester until the last beat.
- burst_i  input  64  write beat from the requester; beat k is line bits [64k+63:64k].
- burst_o  output  64  read beat to the requester, same beat ordering.
- resp_o  output  1  beat-valid strobe; high for exactly 4 consecutive cycles per completed transaction.
- protocol_err_o  output  1  sticky flag: read_i and write_i were high together in IDLE.

Behaviour:
- Reset (reset_n=1 at posedge):
  - state=IDLE; resp_o=0, burst_o=0, protocol_err_o=0; counters cleared.
  - Memory array contents are NOT reset.
  - Reset mid-transaction aborts it; a partial write never commits.
- State machine: IDLE -> WAIT -> BURST -> DONE -> IDLE.
- IDLE:
  - At a posedge with read_i|write_i=1, latch the line index and op, clear the latency counter, go to WAIT. That edge is the accept edge t.
  - If read_i and write_i are both 1: perform the read, ignore the write, set protocol_err_o=1 (held until reset).
- WAIT:
  - Count edges; at edge t+LATENCY enter BURST with beat=0.
  - resp_o=1 and burst_o=line[63:0] (read) are registered at that edge, so both are visible in the cycle after edge t+LATENCY.
- BURST:
  - resp_o=1 for beats 0..3 on consecutive cycles; beat increments each edge.
  - Read: burst_o=word[beat] of the latched line. Memory is read at accept, so a later write to the same line cannot alter an in-flight read.
  - Write: on each edge while resp_o=1, sample burst_i into staging word[beat].
  - Requester protocol: present beat 0 with the request; advance burst_i on the edge where it sees resp_o=1.
  - After beat 3 is sampled, commit the whole 256-bit staging line to the array in one write (atomic), then go to DONE.
- DONE:
  - One cycle; resp_o=0, burst_o=0; read_i/write_i ignored (requester turnaround); then IDLE.
  - Back-to-back requests: the next accept edge is the edge after DONE, so the minimum gap between transactions is 1 cycle of IDLE visibility.
- Abort:
  - If the latched op's request line (read_i or write_i) drops while in WAIT or BURST, go to IDLE on that edge.
  - resp_o and burst_o return to 0 on that edge; staged write data is discarded; no commit.
- Stability:
  - Changes to address_i after accept are ignored.
  - Changes to write_i/read_i of the other op during a transaction are ignored; they do not set protocol_err_o.
- resp_o never exceeds 4 consecutive high cycles and is never high in IDLE, WAIT or DONE.
- burst_o is 0 whenever resp_o=0.

Test Plan:
- Reset then idle: reset_n=1 for 2 cycles -> resp_o=0, burst_o=0, protocol_err_o=0; no resp_o for 20 cycles with read_i=write_i=0.
- Write/read round trip:
  - Write address 0x0000_0040, beats 0x1111..., 0x2222..., 0x3333..., 0x4444... -> resp_o high exactly 4 cycles starting LATENCY edges after accept.
  - Read same address -> burst_o = 0x1111..., 0x2222..., 0x3333..., 0x4444... in order.
- Address decode:
  - Write line at 0x0000_0020, read 0x0000_0020 + MEM_LINES*32 (wrap) -> same data.
  - Read 0x0000_003F -> same line as 0x20 (low bits ignored).
- Aborted write:
  - Line 5 preloaded with all 0xA5; start a write of all 0xFF to it and drop write_i after beat 1.
  - Expect resp_o low next cycle; a subsequent read returns all 0xA5.
- Simultaneous request: read_i=write_i=1 at accept on a line holding 0xDEAD... -> read data returned, line unchanged, protocol_err_o=1 until reset.
- Back-to-back and mid-op reset:
  - Two reads issued as early as the protocol allows -> two separate 4-beat resp_o groups with exactly 1 DONE cycle plus 1 IDLE accept between them.
  - reset_n=1 during BURST of a write -> resp_o=0 next cycle; the line is not modified.
